// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - port indices, flit layout and XY route function for router_port_arbiter
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam logic [2:0] PORT_LEFT  = 3'd0;
  localparam logic [2:0] PORT_RIGHT = 3'd1;
  localparam logic [2:0] PORT_UP    = 3'd2;
  localparam logic [2:0] PORT_DOWN  = 3'd3;
  localparam logic [2:0] PORT_CPU   = 3'd4;

  localparam int FIELD_W   = 16;
  localparam int PAYLOAD_W = 32;
  localparam int FLIT_BITS = 2*FIELD_W + PAYLOAD_W;
  localparam int DST_X_LSB = PAYLOAD_W;
  localparam int DST_Y_LSB = PAYLOAD_W + FIELD_W;

  typedef struct packed {
    logic [FIELD_W-1:0]   dst_y;
    logic [FIELD_W-1:0]   dst_x;
    logic [PAYLOAD_W-1:0] data;
  } flit_t;

  // X is resolved before Y; a flit addressed to this node ejects to the CPU.
  function automatic logic [2:0] xy_route(input logic [FLIT_BITS-1:0] f,
                                          input logic [FIELD_W-1:0] x,
                                          input logic [FIELD_W-1:0] y);
    logic [FIELD_W-1:0] dx;
    logic [FIELD_W-1:0] dy;
    dx = f[DST_X_LSB +: FIELD_W];
    dy = f[DST_Y_LSB +: FIELD_W];
    if (dx > x)      return PORT_RIGHT;
    else if (dx < x) return PORT_LEFT;
    else if (dy < y) return PORT_UP;
    else if (dy > y) return PORT_DOWN;
    else             return PORT_CPU;
  endfunction

endpackage

// File: rtl/router_in_fifo.sv
// rtl/router_in_fifo.sv - 2-entry input flit FIFO with push/pop and occupancy count
module router_in_fifo
  import router_pkg::*;
#(
  parameter int W = FLIT_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;

  // mem0 is always the head; a simultaneous pop/push shifts and refills.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = push_data;
        else                 mem1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          mem0_d = push_data;
        end else begin
          mem0_d = mem1_q;
          mem1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= '0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem0_q;
  assign count     = count_q;

endmodule

// File: rtl/router_port_arbiter.sv
// rtl/router_port_arbiter.sv - 5-port XY switch allocator with per-output round-robin; ROUTER_ARB_STATS_EN adds conflict_cnt
module router_port_arbiter
  import router_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int DATA_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [COORD_W-1:0]               x,
  input  logic [COORD_W-1:0]               y,
  input  logic [4:0]                       in_valid,
  input  logic [5*(2*COORD_W+DATA_W)-1:0]  in_flit,
  output logic [4:0]                       in_ready,
  output logic [4:0]                       out_valid,
  output logic [5*(2*COORD_W+DATA_W)-1:0]  out_flit,
  input  logic [4:0]                       out_ready
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [15:0]                      conflict_cnt
`endif
);

  localparam int FLIT_W = 2*COORD_W + DATA_W;

  logic [FLIT_W-1:0]    head_data [NUM_PORTS];
  logic [1:0]           count     [NUM_PORTS];
  logic [2:0]           req_port  [NUM_PORTS];
  logic [NUM_PORTS-1:0] head_valid, push, pop, out_free, gnt_valid;
  logic [2:0]           gnt_idx   [NUM_PORTS];

  logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
  flit_t                out_flit_q [NUM_PORTS];
  flit_t                out_flit_d [NUM_PORTS];
  logic [2:0]           rr_q [NUM_PORTS];
  logic [2:0]           rr_d [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_in_fifo #(.W(FLIT_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_flit[i*FLIT_W +: FLIT_W]),
      .pop       (pop[i]),
      .head_data (head_data[i]),
      .count     (count[i])
    );
    assign in_ready[i]   = !rst && (count[i] != 2'd2);
    assign push[i]       = in_valid[i] && in_ready[i];
    assign head_valid[i] = (count[i] != 2'd0);
    assign req_port[i]   = xy_route(head_data[i], x, y);
    assign out_flit[i*FLIT_W +: FLIT_W] = out_flit_q[i];
  end

  assign out_valid = out_valid_q;
  assign out_free  = ~out_valid_q | out_ready;

  // Search starts at rr_q[o] and wraps 4->0; first requesting head wins.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] cand;
    sum       = '0;
    cand      = '0;
    gnt_valid = '0;
    pop       = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_idx[o] = '0;
      if (out_free[o]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          sum  = {1'b0, rr_q[o]} + 4'(k);
          cand = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
          if (!gnt_valid[o] && head_valid[cand] && req_port[cand] == 3'(o)) begin
            gnt_valid[o] = 1'b1;
            gnt_idx[o]   = cand;
          end
        end
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid_d[o] = out_valid_q[o];
      out_flit_d[o]  = out_flit_q[o];
      rr_d[o]        = rr_q[o];
      if (out_free[o]) begin
        out_valid_d[o] = gnt_valid[o];
        if (gnt_valid[o]) begin
          out_flit_d[o] = flit_t'(head_data[gnt_idx[o]]);
          rr_d[o]       = (gnt_idx[o] == PORT_CPU) ? 3'd0 : gnt_idx[o] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_flit_q[o] <= '0;
        rr_q[o]       <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      rr_q        <= rr_d;
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (|(head_valid & ~pop) && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_router_port_arbiter.sv
// tb/tb_router_port_arbiter.sv - directed self-checking bench for router_port_arbiter
module tb_router_port_arbiter;

  localparam int PL = 0, PR = 1, PU = 2, PD = 3, PC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  x, y;
  logic [4:0]   in_valid, in_ready, out_valid, out_ready;
  logic [319:0] in_flit, out_flit;
`ifdef ROUTER_ARB_STATS_EN
  logic [15:0]  conflict_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  router_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_ready (out_ready)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [15:0] dy, input logic [15:0] dx, input logic [31:0] d);
    return {dy, dx, d};
  endfunction

  function automatic logic [63:0] oflit(input int o);
    return out_flit[o*64 +: 64];
  endfunction

  task automatic drive(input int i, input logic [63:0] f);
    in_flit[i*64 +: 64] = f;
  endtask

  // Expected DOWN sequence under LEFT/UP contention: L0,U0,L1,U1,...
  function automatic logic [63:0] cont_exp(input int k);
    if (k % 2 == 0) return mk(16'd5, 16'd1, 32'hA000_0000 + 32'(k/2));
    else            return mk(16'd5, 16'd1, 32'hB000_0000 + 32'(k/2));
  endfunction

  initial begin
    int lcnt, ucnt, k, acc, m;
    logic [4:0] rdy;

    rst = 1'b1;
    x = 16'd1;
    y = 16'd1;
    in_valid = 5'b11111;
    in_flit = {5{mk(16'd1, 16'd3, 32'h0BAD_0BAD)}};
    out_ready = 5'b11111;

    repeat (3) begin
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_flit", 64'(|out_flit), 64'd0);
    end
    rst = 1'b0;
    in_valid = 5'b00000;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1f);

    drive(PC, mk(16'd1, 16'd3, 32'hDEADBEEF));
    in_valid = 5'b10000;
    tick();
    in_valid = 5'b00000;
    chk("inj_t1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("inj_valid", 64'(out_valid), 64'b00010);
    chk("inj_flit", oflit(PR), mk(16'd1, 16'd3, 32'hDEADBEEF));
    tick();
    chk("inj_idle", 64'(out_valid), 64'd0);
    chk("inj_hold", oflit(PR), mk(16'd1, 16'd3, 32'hDEADBEEF));

    drive(PL, mk(16'd1, 16'd1, 32'h12345678));
    in_valid = 5'b00001;
    tick();
    in_valid = 5'b00000;
    tick();
    chk("ej_valid", 64'(out_valid), 64'b10000);
    chk("ej_data", 64'(oflit(PC) & 64'hFFFF_FFFF), 64'h12345678);

`ifdef ROUTER_ARB_STATS_EN
    chk("cc_before", 64'(conflict_cnt), 64'd0);
`endif
    lcnt = 0;
    ucnt = 0;
    k = 0;
    in_valid = 5'b00101;
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(PL, mk(16'd5, 16'd1, 32'hA000_0000 + 32'(lcnt)));
      drive(PU, mk(16'd5, 16'd1, 32'hB000_0000 + 32'(ucnt)));
      rdy = in_ready;
      tick();
      if (rdy[PL]) lcnt++;
      if (rdy[PU]) ucnt++;
      if (cyc >= 1) begin
        chk("cont_valid", 64'(out_valid[PD]), 64'd1);
        chk("cont_flit", oflit(PD), cont_exp(k));
        k++;
      end
    end
`ifdef ROUTER_ARB_STATS_EN
    chk("cc_contention", 64'(conflict_cnt), 64'd9);
`endif
    in_valid = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid[PD]) begin
        chk("cont_drain_flit", oflit(PD), cont_exp(k));
        k++;
      end
    end
    chk("cont_total", 64'(k), 64'(lcnt + ucnt));
    chk("cont_idle", 64'(out_valid), 64'd0);

    acc = 0;
    out_ready = 5'b11101;
    in_valid = 5'b10000;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(PC, mk(16'd1, 16'd3, 32'hC000_0000 + 32'(acc)));
      rdy = in_ready;
      tick();
      if (rdy[PC]) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready", 64'(in_ready[PC]), 64'd0);
    chk("bp_staged_valid", 64'(out_valid[PR]), 64'd1);
    chk("bp_staged_flit", oflit(PR), mk(16'd1, 16'd3, 32'hC000_0000));
    in_valid = 5'b00000;
    out_ready = 5'b11111;
    m = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid[PR]) begin
        chk("bp_flit", oflit(PR), mk(16'd1, 16'd3, 32'hC000_0000 + 32'(m)));
        m++;
      end
      tick();
    end
    chk("bp_count", 64'(m), 64'd3);
    chk("bp_idle", 64'(out_valid), 64'd0);

    drive(PL, mk(16'd5, 16'd1, 32'hD000_0000));
    in_valid = 5'b00001;
    tick();
    in_valid = 5'b00000;
    tick();
    chk("mf_pre_flit", oflit(PD), mk(16'd5, 16'd1, 32'hD000_0000));
    tick();
    out_ready = 5'b00000;
    drive(PL, mk(16'd1, 16'd5, 32'hE000_0000));
    drive(PU, mk(16'd1, 16'd0, 32'hF000_0000));
    in_valid = 5'b00101;
    repeat (4) tick();
    chk("mf_full", 64'(in_ready & 5'b00101), 64'd0);
    chk("mf_staged", 64'(out_valid), 64'b00011);
    rst = 1'b1;
    in_valid = 5'b00000;
    tick();
    rst = 1'b0;
    #1;
    chk("mf_rst_valid", 64'(out_valid), 64'd0);
    chk("mf_rst_flit", 64'(|out_flit), 64'd0);
    chk("mf_rst_ready", 64'(in_ready), 64'h1f);
`ifdef ROUTER_ARB_STATS_EN
    chk("mf_rst_cc", 64'(conflict_cnt), 64'd0);
`endif
    out_ready = 5'b11111;
    repeat (3) begin
      tick();
      chk("mf_no_old", 64'(out_valid), 64'd0);
    end

    drive(PL, mk(16'd5, 16'd1, 32'h6000_0000));
    drive(PU, mk(16'd5, 16'd1, 32'h7000_0000));
    in_valid = 5'b00101;
    tick();
    in_valid = 5'b00000;
    tick();
    chk("rr_first_valid", 64'(out_valid), 64'b01000);
    chk("rr_first_flit", oflit(PD), mk(16'd5, 16'd1, 32'h6000_0000));
    tick();
    chk("rr_second_flit", oflit(PD), mk(16'd5, 16'd1, 32'h7000_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_port_arbiter.md
# router_port_arbiter

Clocked switch allocator for one mesh node. It buffers 64-bit flits from the five router inputs (LEFT, RIGHT, UP, DOWN, CPU) and computes each flit's XY output port. Per-output round-robin arbitration then moves at most one flit per output per cycle into a registered output stage with valid/ready backpressure. It replaces the event-driven forwarding path between neighbouring router ports and the local CPU.

## Interface
Parameters:
- COORD_W, 16, width of the x and y coordinate fields.
- DATA_W, 32, width of the payload; FLIT_W = 2*COORD_W + DATA_W = 64.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  COORD_W  this node's x coordinate; static, compared unsigned.
- y  input  COORD_W  this node's y coordinate; static, compared unsigned.
- in_valid  input  5  per-input flit valid. Index 0=LEFT, 1=RIGHT, 2=UP, 3=DOWN, 4=CPU.
- in_flit  input  5*FLIT_W  input i occupies bits [i*64 +: 64]. Flit format {dst_y[63:48], dst_x[47:32], data[31:0]}.
- in_ready  output  5  per-input ready; a flit transfers when in_valid&in_ready.
- out_valid  output  5  per-output valid. Same indices; 4 = eject to CPU.
- out_flit  output  5*FLIT_W  registered output flits.
- out_ready  input  5  downstream ready per output.
- conflict_cnt  output  16  present only with ROUTER_ARB_STATS_EN.

## Operation
- Each input has a 2-entry FIFO. in_ready[i] = (fifo count < 2), driven from registered count, with no combinational path from out_ready. in_ready is 0 while rst=1.
- Route of a FIFO head:
  - dst_x > x → RIGHT; dst_x < x → LEFT.
  - Otherwise dst_y < y → UP; dst_y > y → DOWN.
  - Equal → CPU.
  - A flit may route back out of the port it arrived on; no special handling.
- Output o is free when !out_valid[o] || out_ready[o].
- Requesters for o: inputs whose FIFO head is valid and routes to o.
- Round-robin pointer rr[o] (0..4): search rr[o], rr[o]+1, …, wrapping 4→0; the first requester wins. Arbitration occurs only if o is free.
- On a grant: pop the winner's FIFO, load out_flit[o], set out_valid[o]=1, set rr[o]=(winner+1) mod 5. Without a grant, rr[o] is unchanged.
- If o is free and ungranted: out_valid[o]=0 and out_flit[o] holds its last value.
- Each input head requests exactly one output, so at most one grant per input per cycle.
- A FIFO may pop and push in the same cycle; count is unchanged. Flit order per input is preserved.
- Reset: FIFOs empty, out_valid=0, out_flit=0, rr[*]=0, conflict_cnt=0.
- Reset mid-operation: all buffered and output-staged flits are discarded. No partial state survives.

## Timing
- Latency: a handshake in cycle t gives out_valid in cycle t+2 if uncontended and the output is free.
- Throughput: 1 flit/cycle per input and per output under no contention.
- While out_valid[o]=1 and out_ready[o]=0, out_flit[o] is stable.
- Combinational path out_ready → grant → FIFO pop is internal only. out_* are all registered.
- In the first cycle after rst deasserts, in_ready=5'b11111.

## Configuration
- ROUTER_ARB_STATS_EN defined:
  - conflict_cnt exists.
  - It increments by 1 in every cycle in which at least one valid FIFO head is not granted, whether from lost arbitration or a stalled output.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter logic are absent. Behaviour is otherwise identical.

## Structure
- Package router_pkg holds:
  - port index constants (PORT_LEFT..PORT_CPU, NUM_PORTS=5);
  - flit field position constants;
  - the flit struct typedef;
  - the XY route function.
- Sub-module router_in_fifo: 2-entry FLIT_W FIFO with push/pop/count, instantiated 5 times.

## Test plan
- Reset: hold rst 3 cycles with in_valid=5'b11111 → out_valid=0, out_flit=0, in_ready=0 throughout. The cycle after release, in_ready=5'b11111.
- Injection: x=1, y=1; CPU sends {16'd1,16'd3,32'hDEADBEEF} in cycle t → out_valid[RIGHT]=1 in cycle t+2 with an identical flit; no other output is valid.
- Ejection: LEFT sends {16'd1,16'd1,32'h12345678} → out_valid[CPU] at t+2 with data 32'h12345678.
- Contention: LEFT and UP both stream flits with dst (x=1,y=5), out_ready=1 → DOWN grants alternate LEFT, UP, LEFT, UP. No starvation; conflict_cnt increments each cycle when enabled.
- Backpressure: out_ready[RIGHT]=0; CPU sends 4 flits to x=3 → first flit staged, next two buffered, in_ready[CPU]=0, fourth flit not accepted. Release out_ready → flits delivered in order, none lost or duplicated.
- Reset mid-flight: assert rst with both FIFOs full and outputs stalled → next cycle everything is empty and rr=0. Old flits never appear on outputs.
